// File: rtl/issue_pkg.sv
// Shared definitions for the issue arbiter: default sizes, LSU state encoding
// and the helper that locates one ALU's field in the flattened index bus.
package issue_pkg;

    localparam int DEF_NUM_ENTRIES = 16;
    localparam int DEF_IDX_W       = 4;
    localparam int DEF_NUM_ALU     = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_t;

    // LSB position of ALU k's slot index inside alu_grant_idx
    function automatic int flat_idx_lsb(input int k, input int idx_w);
        return k * idx_w;
    endfunction

endpackage

// File: rtl/issue_arbiter_rr_pick.sv
// Rotating find-first: returns the first set bit of req met when scanning
// slot indices upward from ptr, wrapping modulo N.
module rr_pick
    import issue_pkg::*;
#(
    parameter int N = DEF_NUM_ENTRIES,
    parameter int W = DEF_IDX_W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Scan from the farthest offset down so the nearest hit to ptr wins
    always_comb begin
        logic [W-1:0] slot;
        valid = 1'b0;
        idx   = '0;
        slot  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            slot = W'((int'(ptr) + off) % N);
            if (req[slot]) begin
                valid = 1'b1;
                idx   = slot;
            end
        end
    end

endmodule

// File: rtl/issue_arbiter.sv
// Issue arbiter: picks up to NUM_ALU ready non-memory RS slots for the ALUs
// and one ready memory slot for the LSU each cycle, with rotating priority.
// Grants are registered pulses; issued_mask tells the RS which slots left.
// Optional build macro ISSUE_STATS_EN adds issue/stall statistics counters.
module issue_arbiter
    import issue_pkg::*;
#(
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int NUM_ALU     = DEF_NUM_ALU
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_ENTRIES-1:0]   entry_ready,
    input  logic [NUM_ENTRIES-1:0]   entry_is_mem,
    input  logic [NUM_ALU-1:0]       alu_ready,
    input  logic                     lsu_done,
    output logic [NUM_ALU-1:0]       alu_grant_valid,
    output logic [NUM_ALU*IDX_W-1:0] alu_grant_idx,
    output logic                     lsu_grant_valid,
    output logic [IDX_W-1:0]         lsu_grant_idx,
    output logic [NUM_ENTRIES-1:0]   issued_mask,
    output logic                     lsu_busy
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]              stat_alu_issued,
    output logic [31:0]              stat_lsu_issued,
    output logic [31:0]              stat_lsu_stall
`endif
);

    localparam logic [NUM_ENTRIES-1:0] ENTRY_ONE = NUM_ENTRIES'(1);

    logic [IDX_W-1:0]       rr_ptr;
    lsu_state_t             state;
    lsu_state_t             state_nxt;

    logic [NUM_ENTRIES-1:0] cand;
    logic [NUM_ENTRIES-1:0] alu_cand;
    logic [NUM_ENTRIES-1:0] mem_cand;

    logic                   pick_valid [NUM_ALU];
    logic [IDX_W-1:0]       pick_idx   [NUM_ALU];

    logic                   mem_valid;
    logic [IDX_W-1:0]       mem_idx;

    logic [NUM_ALU-1:0]       alu_valid_p0;
    logic [NUM_ALU*IDX_W-1:0] alu_idx_p0;
    logic [NUM_ENTRIES-1:0]   alu_issued_p0;
    logic                     lsu_valid_p0;
    logic [IDX_W-1:0]         lsu_idx_p0;
    logic [NUM_ENTRIES-1:0]   issued_p0;
    logic                     any_grant_p0;

    // p0: candidate selection from registered state and current inputs.
    // Last cycle's issued_mask doubles as the inflight mask, hiding slots
    // the RS has not yet had a chance to retire.
    assign cand     = entry_ready & ~issued_mask;
    assign alu_cand = cand & ~entry_is_mem;
    assign mem_cand = cand & entry_is_mem;

    // Chain of pickers; each one sees the previous request with its pick removed
    for (genvar p = 0; p < NUM_ALU; p++) begin : g_pick
        logic [NUM_ENTRIES-1:0] req;
        logic                   v;
        logic [IDX_W-1:0]       idx;

        if (p == 0) begin : g_first
            assign req = alu_cand;
        end else begin : g_next
            assign req = g_pick[p-1].req &
                         ~(g_pick[p-1].v ? (ENTRY_ONE << g_pick[p-1].idx) : '0);
        end

        rr_pick #(
            .N (NUM_ENTRIES),
            .W (IDX_W)
        ) u_pick (
            .req   (req),
            .ptr   (rr_ptr),
            .valid (v),
            .idx   (idx)
        );

        assign pick_valid[p] = v;
        assign pick_idx[p]   = idx;
    end

    rr_pick #(
        .N (NUM_ENTRIES),
        .W (IDX_W)
    ) u_mem_pick (
        .req   (mem_cand),
        .ptr   (rr_ptr),
        .valid (mem_valid),
        .idx   (mem_idx)
    );

    // Hand picks out in scan order to ready ALUs in ascending ALU index
    always_comb begin
        int n;
        n             = 0;
        alu_valid_p0  = '0;
        alu_idx_p0    = '0;
        alu_issued_p0 = '0;
        for (int k = 0; k < NUM_ALU; k++) begin
            if (alu_ready[k]) begin
                for (int j = 0; j < NUM_ALU; j++) begin
                    if (j == n && pick_valid[j]) begin
                        alu_valid_p0[k] = 1'b1;
                        alu_idx_p0[flat_idx_lsb(k, IDX_W) +: IDX_W] = pick_idx[j];
                        alu_issued_p0 = alu_issued_p0 | (ENTRY_ONE << pick_idx[j]);
                    end
                end
                n = n + 1;
            end
        end
    end

    // LSU FSM next state and grant; a done pulse in BUSY reopens the unit
    // in the same cycle so a waiting memory op issues back-to-back
    always_comb begin
        state_nxt    = state;
        lsu_valid_p0 = 1'b0;
        lsu_idx_p0   = '0;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    lsu_valid_p0 = 1'b1;
                    lsu_idx_p0   = mem_idx;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (lsu_done) begin
                    if (mem_valid) begin
                        lsu_valid_p0 = 1'b1;
                        lsu_idx_p0   = mem_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign issued_p0    = alu_issued_p0 | (lsu_valid_p0 ? (ENTRY_ONE << lsu_idx_p0) : '0);
    assign any_grant_p0 = (|alu_valid_p0) | lsu_valid_p0;

    // p1: LSU state register; flush abandons any op in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // p1: registered grant outputs and rotating priority pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_grant_valid <= '0;
            alu_grant_idx   <= '0;
            lsu_grant_valid <= 1'b0;
            lsu_grant_idx   <= '0;
            issued_mask     <= '0;
            rr_ptr          <= '0;
        end else if (flush) begin
            alu_grant_valid <= '0;
            alu_grant_idx   <= '0;
            lsu_grant_valid <= 1'b0;
            lsu_grant_idx   <= '0;
            issued_mask     <= '0;
        end else begin
            alu_grant_valid <= alu_valid_p0;
            alu_grant_idx   <= alu_idx_p0;
            lsu_grant_valid <= lsu_valid_p0;
            lsu_grant_idx   <= lsu_idx_p0;
            issued_mask     <= issued_p0;
            if (any_grant_p0) begin
                rr_ptr <= (rr_ptr == IDX_W'(NUM_ENTRIES - 1)) ? '0 : rr_ptr + IDX_W'(1);
            end
        end
    end

    assign lsu_busy = (state == BUSY);

`ifdef ISSUE_STATS_EN
    // Statistics: count registered grants and LSU back-pressure; flush leaves them alone
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_alu_issued <= '0;
            stat_lsu_issued <= '0;
            stat_lsu_stall  <= '0;
        end else begin
            stat_alu_issued <= stat_alu_issued + 32'($countones(alu_grant_valid));
            if (lsu_grant_valid) begin
                stat_lsu_issued <= stat_lsu_issued + 32'd1;
            end
            if ((state == BUSY) && !lsu_done && (|mem_cand)) begin
                stat_lsu_stall <= stat_lsu_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_arbiter.sv
// Bench for issue_arbiter: hand-derived vector table, a wrap-around sequence
// and a randomized run compared against a scan-list reference model.
module tb_issue_arbiter;

    localparam int NE = 16;
    localparam int IW = 4;
    localparam int NA = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [NE-1:0]    entry_ready;
    logic [NE-1:0]    entry_is_mem;
    logic [NA-1:0]    alu_ready;
    logic             lsu_done;
    logic [NA-1:0]    alu_grant_valid;
    logic [NA*IW-1:0] alu_grant_idx;
    logic             lsu_grant_valid;
    logic [IW-1:0]    lsu_grant_idx;
    logic [NE-1:0]    issued_mask;
    logic             lsu_busy;

    always #5 clk = ~clk;

    issue_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .entry_ready     (entry_ready),
        .entry_is_mem    (entry_is_mem),
        .alu_ready       (alu_ready),
        .lsu_done        (lsu_done),
        .alu_grant_valid (alu_grant_valid),
        .alu_grant_idx   (alu_grant_idx),
        .lsu_grant_valid (lsu_grant_valid),
        .lsu_grant_idx   (lsu_grant_idx),
        .issued_mask     (issued_mask),
        .lsu_busy        (lsu_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic          rst;
        logic          fl;
        logic [NE-1:0] rdy;
        logic [NE-1:0] mem;
        logic [NA-1:0] alur;
        logic          done;
        logic [NA-1:0] e_av;
        logic [11:0]   e_ai;
        logic          e_lv;
        logic [IW-1:0] e_li;
        logic [NE-1:0] e_mask;
        logic          e_busy;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    int            m_ptr;
    logic [NE-1:0] m_inflight;
    logic          m_busy;

    function automatic vec_t mk(input logic rst, input logic fl, input logic [NE-1:0] rdy,
                                input logic [NE-1:0] mem, input logic [NA-1:0] alur,
                                input logic done, input logic [NA-1:0] e_av,
                                input logic [11:0] e_ai, input logic e_lv,
                                input logic [IW-1:0] e_li, input logic [NE-1:0] e_mask,
                                input logic e_busy);
        vec_t v;
        v.rst = rst; v.fl = fl; v.rdy = rdy; v.mem = mem; v.alur = alur; v.done = done;
        v.e_av = e_av; v.e_ai = e_ai; v.e_lv = e_lv; v.e_li = e_li;
        v.e_mask = e_mask; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply(input logic rst, input logic fl, input logic [NE-1:0] rdy,
                         input logic [NE-1:0] mem, input logic [NA-1:0] alur, input logic done);
        reset        = rst;
        flush        = fl;
        entry_ready  = rdy;
        entry_is_mem = mem;
        alu_ready    = alur;
        lsu_done     = done;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [NA-1:0] e_av, input logic [11:0] e_ai,
                              input logic e_lv, input logic [IW-1:0] e_li,
                              input logic [NE-1:0] e_mask, input logic e_busy);
        check({tag, ".alu_valid"}, 32'(alu_grant_valid), 32'(e_av));
        check({tag, ".alu_idx"},   32'(alu_grant_idx),   32'(e_ai));
        check({tag, ".lsu_valid"}, 32'(lsu_grant_valid), 32'(e_lv));
        check({tag, ".lsu_idx"},   32'(lsu_grant_idx),   32'(e_li));
        check({tag, ".mask"},      32'(issued_mask),     32'(e_mask));
        check({tag, ".busy"},      32'(lsu_busy),        32'(e_busy));
    endtask

    // Reference: build scan-ordered candidate lists from the pointer, deal
    // them out to ready units, then update pointer/inflight/busy.
    task automatic model_step(input logic rst, input logic fl, input logic [NE-1:0] rdy,
                              input logic [NE-1:0] mem, input logic [NA-1:0] alur,
                              input logic done, output logic [NA-1:0] av,
                              output logic [11:0] ai, output logic lv,
                              output logic [IW-1:0] li, output logic [NE-1:0] mask,
                              output logic busy);
        int            aq[$];
        int            mq[$];
        int            j;
        logic [NE-1:0] c;
        av = '0; ai = '0; lv = 1'b0; li = '0; mask = '0;
        if (rst) begin
            m_ptr = 0; m_inflight = '0; m_busy = 1'b0;
        end else if (fl) begin
            m_inflight = '0; m_busy = 1'b0;
        end else begin
            c = rdy & ~m_inflight;
            for (int off = 0; off < NE; off++) begin
                int s;
                s = (m_ptr + off) % NE;
                if (c[s]) begin
                    if (mem[s]) mq.push_back(s);
                    else        aq.push_back(s);
                end
            end
            j = 0;
            for (int k = 0; k < NA; k++) begin
                if (alur[k] && j < aq.size()) begin
                    av[k] = 1'b1;
                    ai[k*IW +: IW] = IW'(aq[j]);
                    mask = mask | (NE'(1) << aq[j]);
                    j++;
                end
            end
            if (mq.size() > 0 && (!m_busy || done)) begin
                lv = 1'b1;
                li = IW'(mq[0]);
                mask = mask | (NE'(1) << mq[0]);
                m_busy = 1'b1;
            end else if (m_busy && done) begin
                m_busy = 1'b0;
            end
            if (av != '0 || lv) m_ptr = (m_ptr + 1) % NE;
            m_inflight = mask;
        end
        busy = m_busy;
    endtask

    initial begin
        logic [NA-1:0] e_av;
        logic [11:0]   e_ai;
        logic          e_lv;
        logic [IW-1:0] e_li;
        logic [NE-1:0] e_mask;
        logic          e_busy;
        logic          r_rst, r_fl, r_done;
        logic [NE-1:0] r_rdy, r_mem;
        logic [NA-1:0] r_alur;

        reset = 1'b1; flush = 1'b0; entry_ready = '0; entry_is_mem = '0;
        alu_ready = '0; lsu_done = 1'b0;

        //           rst fl  rdy       mem       alur  done av    ai       lv li    mask      busy
        tbl.push_back(mk(1, 0, 16'hFFFF, 16'hFFFF, 3'b111, 1, 3'b000, 12'h000, 0, 4'd0, 16'h0000, 0));
        tbl.push_back(mk(1, 0, 16'hFFFF, 16'hFFFF, 3'b111, 1, 3'b000, 12'h000, 0, 4'd0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 16'hFFFF, 16'hFFFF, 3'b111, 0, 3'b000, 12'h000, 1, 4'd0, 16'h0001, 1));
        tbl.push_back(mk(1, 0, 16'h0000, 16'h0000, 3'b000, 0, 3'b000, 12'h000, 0, 4'd0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 16'h00F0, 16'h0000, 3'b111, 0, 3'b111, 12'h654, 0, 4'd0, 16'h0070, 0));
        tbl.push_back(mk(0, 0, 16'h00F0, 16'h0000, 3'b111, 0, 3'b001, 12'h007, 0, 4'd0, 16'h0080, 0));
        tbl.push_back(mk(0, 0, 16'h000C, 16'h0000, 3'b101, 0, 3'b101, 12'h302, 0, 4'd0, 16'h000C, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 3'b111, 0, 3'b000, 12'h000, 0, 4'd0, 16'h0000, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 16'h0000, 3'b111, 0, 3'b000, 12'h000, 0, 4'd0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 16'h0202, 16'h0202, 3'b111, 0, 3'b000, 12'h000, 1, 4'd1, 16'h0002, 1));
        tbl.push_back(mk(0, 0, 16'h0200, 16'h0202, 3'b111, 0, 3'b000, 12'h000, 0, 4'd0, 16'h0000, 1));
        tbl.push_back(mk(0, 0, 16'h0200, 16'h0202, 3'b111, 0, 3'b000, 12'h000, 0, 4'd0, 16'h0000, 1));
        tbl.push_back(mk(0, 0, 16'h0200, 16'h0202, 3'b111, 1, 3'b000, 12'h000, 1, 4'd9, 16'h0200, 1));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 3'b111, 1, 3'b000, 12'h000, 0, 4'd0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 3'b111, 1, 3'b000, 12'h000, 0, 4'd0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 16'h0010, 16'h0010, 3'b111, 0, 3'b000, 12'h000, 1, 4'd4, 16'h0010, 1));
        tbl.push_back(mk(0, 1, 16'h0101, 16'h0001, 3'b111, 0, 3'b000, 12'h000, 0, 4'd0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 3'b111, 1, 3'b000, 12'h000, 0, 4'd0, 16'h0000, 0));
        tbl.push_back(mk(0, 0, 16'h000A, 16'h0000, 3'b001, 0, 3'b001, 12'h003, 0, 4'd0, 16'h0008, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].fl, tbl[i].rdy, tbl[i].mem, tbl[i].alur, tbl[i].done);
            check_outs($sformatf("vec%0d", i), tbl[i].e_av, tbl[i].e_ai, tbl[i].e_lv,
                       tbl[i].e_li, tbl[i].e_mask, tbl[i].e_busy);
        end

        // Walk the pointer to 15 with one grant per cycle, then check the wrap
        apply(1, 0, '0, '0, 3'b000, 0);
        for (int i = 0; i < 15; i++) begin
            apply(0, 0, NE'(1) << i, '0, 3'b001, 0);
            check_outs($sformatf("walk%0d", i), 3'b001, 12'(i), 0, 4'd0, NE'(1) << i, 0);
        end
        apply(0, 0, 16'h8001, '0, 3'b111, 0);
        check_outs("wrap", 3'b011, 12'h00F, 0, 4'd0, 16'h8001, 0);
        apply(0, 0, 16'h0000, '0, 3'b111, 0);
        check_outs("wrap_idle", 3'b000, 12'h000, 0, 4'd0, 16'h0000, 0);
        apply(0, 0, 16'h8002, '0, 3'b001, 0);
        check_outs("wrap_ptr0", 3'b001, 12'h001, 0, 4'd0, 16'h0002, 0);

        // Randomized run against the reference model
        model_step(1, 0, '0, '0, '0, 0, e_av, e_ai, e_lv, e_li, e_mask, e_busy);
        apply(1, 0, '0, '0, '0, 0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_rst  = ($urandom_range(0, 63) == 0);
            r_fl   = ($urandom_range(0, 31) == 0);
            r_rdy  = NE'($urandom);
            r_mem  = NE'($urandom) & NE'($urandom);
            r_alur = NA'($urandom);
            r_done = ($urandom_range(0, 3) == 0);
            model_step(r_rst, r_fl, r_rdy, r_mem, r_alur, r_done,
                       e_av, e_ai, e_lv, e_li, e_mask, e_busy);
            apply(r_rst, r_fl, r_rdy, r_mem, r_alur, r_done);
            check_outs($sformatf("rand%0d", cyc), e_av, e_ai, e_lv, e_li, e_mask, e_busy);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
